load_seq_ctrl: RTL and testbench

//  Load sequencer between the core load path and the data-memory port. Accepts one load (addr + lb/lh/signext),

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/load_align_merge.sv | 27 ++
 rtl/load_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_load_seq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load sequencer: FSM states, access size encodings and
// helpers for decoding the load size, detecting split accesses and sizing the timeout counter.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ1  = 3'd1,
    WAIT1 = 3'd2,
    REQ2  = 3'd3,
    WAIT2 = 3'd4,
    DONE  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SZ_W = 2'd0,
    SZ_H = 2'd1,
    SZ_B = 2'd2
  } size_e;

  // The counter must hold values up to tmo-1; keep at least one bit when the timeout is disabled.
  function automatic int tmo_cnt_w(input int tmo);
    return (tmo < 2) ? 1 : $clog2(tmo + 1);
  endfunction

  function automatic size_e decode_size(input logic lb, input logic lh);
    if (lb && !lh) return SZ_B;
    if (lh && !lb) return SZ_H;
    return SZ_W;
  endfunction

  function automatic logic needs_split(input size_e size, input logic [1:0] off);
    return ((size == SZ_H) && (off == 2'd3)) || ((size == SZ_W) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/load_align_merge.sv
// Combinational merge of two aligned words, byte alignment by the address offset,
// and sign/zero extension to the final 32-bit load result.
module load_align_merge
  import lsu_pkg::*;
(
  input  logic [31:0] hi_word,
  input  logic [31:0] lo_word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        signext,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = 32'({hi_word, lo_word} >> {offset, 3'b000});

  always_comb begin
    result = shifted;
    case (size)
      SZ_B:    result = {{24{signext & shifted[7]}}, shifted[7:0]};
      SZ_H:    result = {{16{signext & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_seq_ctrl.sv
// Load sequencer between the core load path and the data-memory port.
// Define MISALIGNED_SPLIT_EN to split misaligned loads into two word accesses; otherwise they fail with err_o.
module load_seq_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int RESP_TMO = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              lb_i,
  input  logic              lh_i,
  input  logic              load_signext_i,
  output logic              busy_o,
  output logic              data_req_o,
  output logic [ADDR_W-1:0] data_addr_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [31:0]       data_rdata_i,
  input  logic              data_err_i,
  output logic [31:0]       rdata_o,
  output logic              rvalid_o,
  output logic              err_o
);

  localparam int CNT_W = tmo_cnt_w(RESP_TMO);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((RESP_TMO > 0) ? RESP_TMO - 1 : 0);

  state_e           state;
  size_e            size_q;
  logic [1:0]       offset_q;
  logic             signext_q;
  logic [CNT_W-1:0] cnt;
  logic             tmo_hit;
  logic [31:0]      hi_sel;
  logic [31:0]      lo_sel;
  logic [31:0]      merged;
  logic             split_req;

  assign tmo_hit   = (RESP_TMO != 0) && (cnt == TMO_LAST);
  assign split_req = needs_split(decode_size(lb_i, lh_i), addr_i[1:0]);

`ifdef MISALIGNED_SPLIT_EN
  logic        split_q;
  logic [31:0] lo_buf;

  // The second word is live on the bus during WAIT2; the first one was buffered.
  assign hi_sel = (state == WAIT2) ? data_rdata_i : 32'h0;
  assign lo_sel = (state == WAIT2) ? lo_buf : data_rdata_i;
`else
  assign hi_sel = 32'h0;
  assign lo_sel = data_rdata_i;
`endif

  load_align_merge u_merge (
    .hi_word (hi_sel),
    .lo_word (lo_sel),
    .offset  (offset_q),
    .size    (size_q),
    .signext (signext_q),
    .result  (merged)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      size_q      <= SZ_W;
      offset_q    <= 2'd0;
      signext_q   <= 1'b0;
      cnt         <= '0;
      busy_o      <= 1'b0;
      data_req_o  <= 1'b0;
      data_addr_o <= '0;
      rdata_o     <= 32'h0;
      rvalid_o    <= 1'b0;
      err_o       <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
      split_q     <= 1'b0;
      lo_buf      <= 32'h0;
`endif
    end else begin
      rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            size_q    <= decode_size(lb_i, lh_i);
            offset_q  <= addr_i[1:0];
            signext_q <= load_signext_i;
            cnt       <= '0;
            busy_o    <= 1'b1;
`ifdef MISALIGNED_SPLIT_EN
            split_q     <= split_req;
            state       <= REQ1;
            data_req_o  <= 1'b1;
            data_addr_o <= {addr_i[ADDR_W-1:2], 2'b00};
`else
            if (split_req) begin
              state    <= DONE;
              rvalid_o <= 1'b1;
              err_o    <= 1'b1;
              rdata_o  <= 32'h0;
            end else begin
              state       <= REQ1;
              data_req_o  <= 1'b1;
              data_addr_o <= {addr_i[ADDR_W-1:2], 2'b00};
            end
`endif
          end
        end
        // A grant wins over a same-cycle timeout and over any rvalid seen while requesting.
        REQ1, REQ2: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            cnt        <= '0;
            state      <= (state == REQ1) ? WAIT1 : WAIT2;
          end else if (tmo_hit) begin
            data_req_o <= 1'b0;
            state      <= DONE;
            rvalid_o   <= 1'b1;
            err_o      <= 1'b1;
            rdata_o    <= 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT1, WAIT2: begin
          if (data_rvalid_i) begin
            cnt <= '0;
`ifdef MISALIGNED_SPLIT_EN
            if ((state == WAIT1) && split_q && !data_err_i) begin
              lo_buf      <= data_rdata_i;
              data_req_o  <= 1'b1;
              data_addr_o <= data_addr_o + ADDR_W'(4);
              state       <= REQ2;
            end else
`endif
            begin
              state    <= DONE;
              rvalid_o <= 1'b1;
              err_o    <= data_err_i;
              rdata_o  <= data_err_i ? 32'h0 : merged;
            end
          end else if (tmo_hit) begin
            state    <= DONE;
            rvalid_o <= 1'b1;
            err_o    <= 1'b1;
            rdata_o  <= 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          err_o  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy_o     <= 1'b0;
          data_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_seq_ctrl.sv
// Table-driven bench for load_seq_ctrl: every cycle's inputs and expected outputs are planned
// up front from the load rules, then one process drives and one process compares each cycle.
module tb_load_seq_ctrl;

  localparam int N       = 96;
  localparam int TMO     = 4;
  localparam int END_CYC = 80;
  localparam int N_RES   = 10;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic [31:0] addr_i;
  logic        lb_i;
  logic        lh_i;
  logic        load_signext_i;
  logic        busy_o;
  logic        data_req_o;
  logic [31:0] data_addr_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        data_err_i;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        err_o;

  always #5 clk = ~clk;

  load_seq_ctrl #(.ADDR_W(32), .RESP_TMO(TMO)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .addr_i         (addr_i),
    .lb_i           (lb_i),
    .lh_i           (lh_i),
    .load_signext_i (load_signext_i),
    .busy_o         (busy_o),
    .data_req_o     (data_req_o),
    .data_addr_o    (data_addr_o),
    .data_gnt_i     (data_gnt_i),
    .data_rvalid_i  (data_rvalid_i),
    .data_rdata_i   (data_rdata_i),
    .data_err_i     (data_err_i),
    .rdata_o        (rdata_o),
    .rvalid_o       (rvalid_o),
    .err_o          (err_o)
  );

  logic        drv_rst [N];
  logic        drv_req [N];
  logic        drv_lb [N];
  logic        drv_lh [N];
  logic        drv_se [N];
  logic        drv_gnt [N];
  logic        drv_rv [N];
  logic        drv_err [N];
  logic [31:0] drv_addr [N];
  logic [31:0] drv_rdata [N];

  logic        exp_busy [N];
  logic        exp_req [N];
  logic        exp_rvalid [N];
  logic        exp_err [N];
  logic        exp_zero [N];
  logic [31:0] exp_addr [N];
  logic [31:0] exp_rdata [N];

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] got_rdata_q [$];
  logic        got_err_q [$];

  task automatic checkOutput(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, c, act, req);
    end
  endtask

  task automatic applyStimulus(input int c);
    if (c < N) begin
      rst_ni         = drv_rst[c];
      req_i          = drv_req[c];
      addr_i         = drv_addr[c];
      lb_i           = drv_lb[c];
      lh_i           = drv_lh[c];
      load_signext_i = drv_se[c];
      data_gnt_i     = drv_gnt[c];
      data_rvalid_i  = drv_rv[c];
      data_rdata_i   = drv_rdata[c];
      data_err_i     = drv_err[c];
    end else begin
      rst_ni        = 1'b1;
      req_i         = 1'b0;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
    end
  endtask

  // Load result from little-endian bytes of the two words, starting at the address offset.
  function automatic logic [31:0] model_result(input logic [31:0] addr, input logic lb, input logic lh,
                                               input logic se, input logic [31:0] w_lo, input logic [31:0] w_hi);
    logic [7:0]  b [8];
    logic [15:0] h;
    int          off;
    for (int i = 0; i < 4; i++) begin
      b[i]     = w_lo[8*i +: 8];
      b[i + 4] = w_hi[8*i +: 8];
    end
    off = int'(addr[1:0]);
    h   = {b[off + 1], b[off]};
    if (lb && !lh) return se ? {{24{b[off][7]}}, b[off]} : {24'h0, b[off]};
    if (lh && !lb) return se ? {{16{h[15]}}, h} : {16'h0, h};
    return {b[off + 3], b[off + 2], b[off + 1], b[off]};
  endfunction

  task automatic clear_cycle(input int c);
    drv_req[c] = 1'b0; drv_lb[c] = 1'b0; drv_lh[c] = 1'b0; drv_se[c] = 1'b0;
    drv_gnt[c] = 1'b0; drv_rv[c] = 1'b0; drv_err[c] = 1'b0;
    drv_addr[c] = 32'h0; drv_rdata[c] = 32'h0;
    exp_busy[c] = 1'b0; exp_req[c] = 1'b0; exp_rvalid[c] = 1'b0; exp_err[c] = 1'b0;
    exp_zero[c] = 1'b0; exp_addr[c] = 32'h0; exp_rdata[c] = 32'h0;
  endtask

  // gN/rN: cycles of delay before grant/rvalid for access N; a value >= TMO means it never comes.
  task automatic plan_load(input int t0, input logic [31:0] addr, input logic lb, input logic lh, input logic se,
                           input int g1, input int r1, input logic [31:0] w1, input logic e1,
                           input int g2, input int r2, input logic [31:0] w2, input logic e2,
                           output int done_c);
    int          c, n_acc, g, r;
    logic [31:0] a, w;
    logic        e, err, split, stop, is_half, is_byte, is_word;
    is_half = lh && !lb;
    is_byte = lb && !lh;
    is_word = !is_half && !is_byte;
    split   = (is_half && addr[1:0] == 2'd3) || (is_word && addr[1:0] != 2'd0);
    drv_req[t0] = 1'b1; drv_addr[t0] = addr; drv_lb[t0] = lb; drv_lh[t0] = lh; drv_se[t0] = se;
    c     = t0 + 1;
    err   = 1'b0;
    stop  = 1'b0;
    n_acc = split ? 2 : 1;
`ifndef MISALIGNED_SPLIT_EN
    if (split) begin
      err  = 1'b1;
      stop = 1'b1;
    end
`endif
    for (int k = 0; k < n_acc && !stop; k++) begin
      a = {addr[31:2], 2'b00} + 32'(4 * k);
      g = (k == 0) ? g1 : g2;
      r = (k == 0) ? r1 : r2;
      w = (k == 0) ? w1 : w2;
      e = (k == 0) ? e1 : e2;
      if (g >= TMO) begin
        for (int i = 0; i < TMO; i++) begin
          exp_busy[c] = 1'b1; exp_req[c] = 1'b1; exp_addr[c] = a; c++;
        end
        err = 1'b1; stop = 1'b1;
      end else begin
        for (int i = 0; i <= g; i++) begin
          exp_busy[c] = 1'b1; exp_req[c] = 1'b1; exp_addr[c] = a;
          if (i == g) drv_gnt[c] = 1'b1;
          c++;
        end
        if (r >= TMO) begin
          for (int i = 0; i < TMO; i++) begin
            exp_busy[c] = 1'b1; c++;
          end
          err = 1'b1; stop = 1'b1;
        end else begin
          for (int i = 0; i <= r; i++) begin
            exp_busy[c] = 1'b1;
            if (i == r) begin
              drv_rv[c] = 1'b1; drv_rdata[c] = w; drv_err[c] = e;
            end
            c++;
          end
          if (e) begin
            err = 1'b1; stop = 1'b1;
          end
        end
      end
    end
    exp_busy[c]   = 1'b1;
    exp_rvalid[c] = 1'b1;
    exp_err[c]    = err;
    exp_rdata[c]  = err ? 32'h0 : model_result(addr, lb, lh, se, w1, split ? w2 : 32'h0);
    done_c        = c;
  endtask

  // Planner and driver
  initial begin
    int d, rc;
    for (int c = 0; c < N; c++) begin
      clear_cycle(c);
      drv_rst[c] = 1'b1;
    end
    for (int c = 0; c <= 2; c++) begin
      drv_rst[c]  = 1'b0;
      exp_zero[c] = 1'b1;
    end
    plan_load(5,  32'h100, 1'b0, 1'b0, 1'b0, 0, 0, 32'h8899AABB, 1'b0, 0, 0, 32'h0, 1'b0, d);
    plan_load(10, 32'h103, 1'b1, 1'b0, 1'b1, 0, 0, 32'h80123456, 1'b0, 0, 0, 32'h0, 1'b0, d);
    plan_load(14, 32'h103, 1'b1, 1'b0, 1'b0, 0, 0, 32'h80123456, 1'b0, 0, 0, 32'h0, 1'b0, d);
    drv_rv[15] = 1'b1; drv_rdata[15] = 32'hDEADBEEF; drv_err[15] = 1'b1;
    plan_load(18, 32'h203, 1'b0, 1'b1, 1'b1, 0, 0, 32'h11000000, 1'b0, 0, 0, 32'h00000022, 1'b0, d);
    plan_load(25, 32'h300, 1'b0, 1'b0, 1'b0, 3, 0, 32'h12345678, 1'b1, 0, 0, 32'h0, 1'b0, d);
    drv_req[27] = 1'b1; drv_addr[27] = 32'h999;
    plan_load(33, 32'h400, 1'b0, 1'b0, 1'b0, 99, 0, 32'h0, 1'b0, 0, 0, 32'h0, 1'b0, d);
    drv_rv[40] = 1'b1; drv_rdata[40] = 32'h55AA55AA;
    plan_load(42, 32'h500, 1'b0, 1'b0, 1'b0, 0, 99, 32'h0, 1'b0, 0, 0, 32'h0, 1'b0, d);
    plan_load(50, 32'h602, 1'b0, 1'b0, 1'b0, 0, 0, 32'hAABBCCDD, 1'b0, 1, 0, 32'h11223344, 1'b0, d);
    plan_load(58, 32'h702, 1'b0, 1'b1, 1'b1, 0, 0, 32'h80015A5A, 1'b0, 0, 0, 32'h0, 1'b0, d);
`ifdef MISALIGNED_SPLIT_EN
    plan_load(63, 32'h801, 1'b0, 1'b0, 1'b0, 0, 0, 32'h01020304, 1'b0, 0, 2, 32'h05060708, 1'b0, d);
    rc = 68;
`else
    plan_load(63, 32'h800, 1'b0, 1'b0, 1'b0, 0, 3, 32'h01020304, 1'b0, 0, 0, 32'h0, 1'b0, d);
    rc = 66;
`endif
    for (int c = rc; c < 72; c++) clear_cycle(c);
    drv_rst[rc] = 1'b0; drv_rst[rc + 1] = 1'b0;
    exp_zero[rc] = 1'b1; exp_zero[rc + 1] = 1'b1;
    plan_load(72, 32'h900, 1'b0, 1'b0, 1'b0, 1, 1, 32'hCAFEF00D, 1'b0, 0, 0, 32'h0, 1'b0, d);

    applyStimulus(0);
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      applyStimulus(cyc);
    end
  end

  // Per-cycle compare against the plan, then literal checks on the collected results
  initial begin
    logic [31:0] lit_rdata [N_RES];
    logic        lit_err [N_RES];
`ifdef MISALIGNED_SPLIT_EN
    lit_rdata = '{32'h8899AABB, 32'hFFFFFF80, 32'h00000080, 32'h00002211, 32'h0,
                  32'h0, 32'h0, 32'h3344AABB, 32'hFFFF8001, 32'hCAFEF00D};
    lit_err   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    lit_rdata = '{32'h8899AABB, 32'hFFFFFF80, 32'h00000080, 32'h0, 32'h0,
                  32'h0, 32'h0, 32'h0, 32'hFFFF8001, 32'hCAFEF00D};
    lit_err   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < END_CYC) begin
        if (exp_zero[cyc]) begin
          checkOutput("reset_busy", cyc, 32'(busy_o), 32'h0);
          checkOutput("reset_data_req", cyc, 32'(data_req_o), 32'h0);
          checkOutput("reset_data_addr", cyc, data_addr_o, 32'h0);
          checkOutput("reset_rvalid", cyc, 32'(rvalid_o), 32'h0);
          checkOutput("reset_err", cyc, 32'(err_o), 32'h0);
          checkOutput("reset_rdata", cyc, rdata_o, 32'h0);
        end else begin
          checkOutput("busy_o", cyc, 32'(busy_o), 32'(exp_busy[cyc]));
          checkOutput("data_req_o", cyc, 32'(data_req_o), 32'(exp_req[cyc]));
          checkOutput("rvalid_o", cyc, 32'(rvalid_o), 32'(exp_rvalid[cyc]));
          if (exp_req[cyc]) checkOutput("data_addr_o", cyc, data_addr_o, exp_addr[cyc]);
          if (exp_rvalid[cyc]) begin
            checkOutput("err_o", cyc, 32'(err_o), 32'(exp_err[cyc]));
            checkOutput("rdata_o", cyc, rdata_o, exp_rdata[cyc]);
          end
        end
        if (rvalid_o) begin
          got_rdata_q.push_back(rdata_o);
          got_err_q.push_back(err_o);
        end
      end else if (cyc >= END_CYC) begin
        checkOutput("model_lb_signext", 0, model_result(32'h103, 1'b1, 1'b0, 1'b1, 32'h80123456, 32'h0), 32'hFFFFFF80);
        checkOutput("model_lh_split", 0, model_result(32'h203, 1'b0, 1'b1, 1'b1, 32'h11000000, 32'h22), 32'h00002211);
        checkOutput("model_lw_split", 0, model_result(32'h602, 1'b0, 1'b0, 1'b0, 32'hAABBCCDD, 32'h11223344), 32'h3344AABB);
        checkOutput("result_count", cyc, 32'(got_rdata_q.size()), 32'(N_RES));
        for (int i = 0; i < N_RES; i++) begin
          if (i < got_rdata_q.size()) begin
            checkOutput($sformatf("result%0d_rdata", i), cyc, got_rdata_q[i], lit_rdata[i]);
            checkOutput($sformatf("result%0d_err", i), cyc, 32'(got_err_q[i]), 32'(lit_err[i]));
          end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  end

endmodule
